snail_pattern_gen: RTL and testbench



---
 rtl/snail_gen_pkg.sv | 13 +
 rtl/snail_pattern_gen_if.sv | 43 ++++
 rtl/snail_en_counter.sv | 38 +++
 rtl/snail_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_snail_pattern_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/snail_gen_pkg.sv
// rtl/snail_gen_pkg.sv - shared types and constants for the snail pattern generator
package snail_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } gen_state_e;

  localparam logic [4:0] SNAIL_PAT_DEFAULT = 5'b10110;

endpackage

// File: rtl/snail_pattern_gen_if.sv
// rtl/snail_pattern_gen_if.sv - control/stream bundle of snail_pattern_gen (SNAIL_GEN_ERR_INJECT_EN adds err_en/err_idx)
interface snail_pattern_gen_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);

  logic             en;
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             a;
  logic             valid;
  logic             last_bit;
  logic             busy;
  logic             done;

`ifdef SNAIL_GEN_ERR_INJECT_EN
  logic                     err_en;
  logic [$clog2(PAT_W)-1:0] err_idx;

  modport master (
    output en, start, repeat_cnt, gap_len, err_en, err_idx,
    input  a, valid, last_bit, busy, done
  );

  modport slave (
    input  en, start, repeat_cnt, gap_len, err_en, err_idx,
    output a, valid, last_bit, busy, done
  );
`else
  modport master (
    output en, start, repeat_cnt, gap_len,
    input  a, valid, last_bit, busy, done
  );

  modport slave (
    input  en, start, repeat_cnt, gap_len,
    output a, valid, last_bit, busy, done
  );
`endif

endinterface

// File: rtl/snail_en_counter.sv
// rtl/snail_en_counter.sv - en-gated down counter with load and zero flag
module snail_en_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over decrement; the count parks at zero instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/snail_pattern_gen.sv
// rtl/snail_pattern_gen.sv - serial MSB-first pattern transmitter with repeats and gaps (SNAIL_GEN_ERR_INJECT_EN adds bit inversion)
module snail_pattern_gen
  import snail_gen_pkg::*;
#(
  parameter int               PAT_W = 5,
  parameter logic [PAT_W-1:0] PAT   = PAT_W'(SNAIL_PAT_DEFAULT),
  parameter int               CNT_W = 4,
  parameter int               GAP_W = 4
) (
  input logic              clk,
  input logic              rst,
  snail_pattern_gen_if.slave bus
);

  localparam int IDX_W = $clog2(PAT_W);

  gen_state_e       state_q, state_d;
  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             bit_load;
  logic [IDX_W-1:0] bit_cnt;
  logic             bit_zero;
  logic [IDX_W-1:0] bit_idx;

  logic             gap_load;
  logic [GAP_W-1:0] gap_cnt_unused;
  logic             gap_zero;

  logic             send_st;
  logic             flip;

`ifdef SNAIL_GEN_ERR_INJECT_EN
  logic             err_en_q, err_en_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
`endif

  // bits remaining in the current frame; zero means the last bit is on a
  snail_en_counter #(.W(IDX_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (IDX_W'(PAT_W - 1)),
    .en       (bus.en && (state_q == SEND)),
    .cnt      (bit_cnt),
    .zero     (bit_zero)
  );

  // gap bits remaining; loaded with gap_len-1 so zero marks the final gap bit
  snail_en_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .en       (bus.en && (state_q == GAP)),
    .cnt      (gap_cnt_unused),
    .zero     (gap_zero)
  );

  assign bit_idx = IDX_W'(PAT_W - 1) - bit_cnt;

  // next-state, shift register and frame bookkeeping
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    bit_load = 1'b0;
    gap_load = 1'b0;
`ifdef SNAIL_GEN_ERR_INJECT_EN
    err_en_d  = err_en_q;
    err_idx_d = err_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frames_d = bus.repeat_cnt;
          gap_d    = bus.gap_len;
          sreg_d   = PAT;
          bit_load = 1'b1;
`ifdef SNAIL_GEN_ERR_INJECT_EN
          err_en_d  = bus.err_en;
          err_idx_d = bus.err_idx;
`endif
          state_d  = (bus.repeat_cnt != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (bus.en) begin
          sreg_d = {sreg_q[PAT_W-2:0], 1'b0};
          if (bit_zero) begin
            frames_d = frames_q - CNT_W'(1);
            if (frames_q > CNT_W'(1)) begin
              if (gap_q != '0) begin
                state_d  = GAP;
                gap_load = 1'b1;
              end else begin
                sreg_d   = PAT;
                bit_load = 1'b1;
              end
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      GAP: begin
        if (bus.en && gap_zero) begin
          state_d  = SEND;
          sreg_d   = PAT;
          bit_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      frames_q <= '0;
      gap_q    <= '0;
`ifdef SNAIL_GEN_ERR_INJECT_EN
      err_en_q  <= 1'b0;
      err_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
`ifdef SNAIL_GEN_ERR_INJECT_EN
      err_en_q  <= err_en_d;
      err_idx_q <= err_idx_d;
`endif
    end
  end

`ifdef SNAIL_GEN_ERR_INJECT_EN
  // an out-of-range err_idx never equals bit_idx, so nothing is inverted
  assign flip = err_en_q && (bit_idx == err_idx_q);
`else
  assign flip = 1'b0;
`endif

  assign send_st      = (state_q == SEND);
  assign bus.valid    = send_st;
  assign bus.a        = send_st & (sreg_q[PAT_W-1] ^ flip);
  assign bus.last_bit = send_st & (bit_idx == IDX_W'(PAT_W - 1));
  assign bus.busy     = send_st | (state_q == GAP);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_snail_pattern_gen.sv
// tb/tb_snail_pattern_gen.sv - self-checking bench for snail_pattern_gen
module tb_snail_pattern_gen;

  localparam int PAT_W = 5;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [4:0] pat_bits;

  snail_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  snail_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".a"}, 32'(bus.a), 0);
    chk({tag, ".valid"}, 32'(bus.valid), 0);
    chk({tag, ".last_bit"}, 32'(bus.last_bit), 0);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
  endtask

  task automatic drive_err(input int ee, input int ei);
`ifdef SNAIL_GEN_ERR_INJECT_EN
    bus.err_en  = 1'(ee);
    bus.err_idx = 3'(ei);
`endif
  endtask

  // mode: 0 random en, 1 en always high, 2 en high every third cycle
  task automatic run_tx(input int rc, input int gl, input int mode, input int ee, input int ei,
                        output int vcyc, output int hits, output int lcnt);
    logic exp_a[$];
    logic exp_v[$];
    logic exp_l[$];
    logic [4:0] sh;
    logic b;
    logic en_now;
    int pos, cyc;
    bit finished;
    vcyc = 0; hits = 0; lcnt = 0; sh = '0;
    for (int f = 0; f < rc; f++) begin
      for (int i = 0; i < PAT_W; i++) begin
        b = pat_bits[PAT_W-1-i];
        if (ee != 0 && ei == i) b = ~b;
        exp_a.push_back(b); exp_v.push_back(1'b1); exp_l.push_back(i == PAT_W-1);
      end
      if (f < rc - 1)
        for (int g = 0; g < gl; g++) begin
          exp_a.push_back(1'b0); exp_v.push_back(1'b0); exp_l.push_back(1'b0);
        end
    end
    @(negedge clk);
    bus.start = 1'b1; bus.repeat_cnt = 4'(rc); bus.gap_len = 4'(gl);
    drive_err(ee, ei);
    bus.en = 1'($urandom);
    @(posedge clk);
    pos = 0; cyc = 0; finished = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      if (pos < exp_a.size()) begin
        chk("stream.a", 32'(bus.a), 32'(exp_a[pos]));
        chk("stream.valid", 32'(bus.valid), 32'(exp_v[pos]));
        chk("stream.last_bit", 32'(bus.last_bit), 32'(exp_l[pos]));
        chk("stream.busy", 32'(bus.busy), 1);
        chk("stream.done", 32'(bus.done), 0);
        if (bus.valid === 1'b1) vcyc++;
        if (bus.last_bit === 1'b1) lcnt++;
        en_now = (mode == 1) ? 1'b1 : (mode == 2) ? (cyc % 3 == 2) : 1'($urandom);
        if (en_now && bus.valid === 1'b1) begin
          sh = {sh[3:0], bus.a};
          if (sh == 5'b10110) hits++;
        end
        bus.start = ($urandom_range(0, 7) == 0);
        bus.repeat_cnt = 4'($urandom);
        bus.gap_len = 4'($urandom);
        drive_err(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        bus.en = en_now;
        if (en_now) pos++;
      end else begin
        chk("end.done", 32'(bus.done), 1);
        chk("end.busy", 32'(bus.busy), 0);
        chk("end.valid", 32'(bus.valid), 0);
        chk("end.a", 32'(bus.a), 0);
        if (mode == 1) chk("end.latency", 32'(cyc), 32'(exp_a.size()));
        bus.start = 1'b0;
        bus.en = 1'($urandom);
        @(negedge clk);
        chk_quiet("idle_after_done");
        finished = 1;
      end
      cyc++;
    end
    if (!finished) chk("timeout", 1, 0);
  endtask

  initial begin
    int vc, ht, lc;
    tests = 0; fails = 0;
    pat_bits = 5'b10110;
    rst = 1'b1;
    bus.en = 1'b1; bus.start = 1'b1; bus.repeat_cnt = 4'd3; bus.gap_len = 4'd1;
    drive_err(1, 0);

    // reset held with en and start high
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    bus.start = 1'b0;
    drive_err(0, 0);
    rst = 1'b0;

    // single frame, en always high: 1,0,1,1,0 then done
    run_tx(1, 0, 1, 0, 0, vc, ht, lc);
    chk("single.valid_cycles", 32'(vc), 5);
    chk("single.last_pulses", 32'(lc), 1);

    // en every third cycle: bits held 3 cycles
    run_tx(1, 0, 2, 0, 0, vc, ht, lc);
    chk("slow.valid_cycles", 32'(vc), 15);
    chk("slow.detector_hits", 32'(ht), 1);

    // three frames with two-bit gaps
    run_tx(3, 2, 1, 0, 0, vc, ht, lc);
    chk("gap.valid_cycles", 32'(vc), 15);
    chk("gap.last_pulses", 32'(lc), 3);

    // reset after the third bit of a frame
    @(negedge clk);
    bus.start = 1'b1; bus.repeat_cnt = 4'd1; bus.gap_len = 4'd0; bus.en = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midreset.pre_a", 32'(bus.a), 1);
    chk("midreset.pre_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 chk_quiet("midreset.async");
    @(negedge clk);
    chk_quiet("midreset.held");
    rst = 1'b0;
    run_tx(1, 0, 0, 0, 0, vc, ht, lc);
    chk("restart.valid_cycles_min", 32'(vc >= 5), 1);

    // zero frames: immediate done, no valid
    run_tx(0, 3, 1, 0, 0, vc, ht, lc);
    chk("zero.valid_cycles", 32'(vc), 0);

    // maximum repeat count, back-to-back frames
    run_tx(15, 0, 1, 0, 0, vc, ht, lc);
    chk("max.last_pulses", 32'(lc), 15);

`ifdef SNAIL_GEN_ERR_INJECT_EN
    run_tx(1, 0, 1, 1, 2, vc, ht, lc);
    chk("err.detector_hits", 32'(ht), 0);
    run_tx(1, 0, 1, 1, 6, vc, ht, lc);
    chk("err_oob.detector_hits", 32'(ht), 1);
`endif

    // randomized frames
    for (int k = 0; k < 10; k++) begin
      int rc, gl, ee, ei;
      rc = int'($urandom_range(0, 4));
      gl = int'($urandom_range(0, 3));
`ifdef SNAIL_GEN_ERR_INJECT_EN
      ee = int'($urandom_range(0, 1));
      ei = int'($urandom_range(0, 7));
`else
      ee = 0;
      ei = 0;
`endif
      run_tx(rc, gl, 0, ee, ei, vc, ht, lc);
      chk("rand.last_pulses_min", 32'(lc >= rc), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
